pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline stall/flush controller.
//
// Resolves load-use hazards, branch waits and multi-cycle EX operations into
// per-stage enable/flush controls. Controls are combinational from state, the
// down-counter and the inputs. The state and the counter are registered.
//
// Parameters:
//   MC_LAT  EX occupancy of a multi-cycle op in cycles (2..255)
//   PERF_W  width of the performance counters
// Ports:
//   clk, rst                     clock and asynchronous active-low reset
//   load_stall, branch_stall     hazard requests from decode
//   mc_start                     multi-cycle op present in EX (level)
//   br_resolve, br_taken         branch resolution from EX
//   mem_wait                     data memory not ready; freezes everything
//   pc_en .. ex_mem_flush        pipeline register controls
//   pc_redirect                  select branch target for the next PC
//   busy                         controller is not in the run state
//   perf_stall_cnt/flush_cnt     saturating counters of stall and flush cycles
// Build option:
//   PIPE_CTRL_PERF_EN            enables the counters (otherwise tied to 0)
module pipe_ctrl #(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_stall,
    input  logic              branch_stall,
    input  logic              mc_start,
    input  logic              br_resolve,
    input  logic              br_taken,
    input  logic              mem_wait,
    output logic              pc_en,
    output logic              pc_redirect,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_en,
    output logic              ex_mem_flush,
    output logic              busy,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
);

    typedef enum logic [1:0] {StRun, StBrWait, StMcBusy} state_e;

    // The first EX cycle happens in RUN, the last in MC_BUSY with cnt==0.
    localparam logic [7:0] McLoad = 8'(MC_LAT - 2);

    state_e     state;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= StRun;
            cnt   <= 8'd0;
        end else if (!mem_wait) begin
            unique case (state)
                StRun: begin
                    if (mc_start) begin
                        state <= StMcBusy;
                        cnt   <= McLoad;
                    end else if (!load_stall && branch_stall) begin
                        // A simultaneous load stall wins; the branch is seen again later.
                        state <= StBrWait;
                    end
                end
                StBrWait: begin
                    if (br_resolve) state <= StRun;
                end
                StMcBusy: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    else             state <= StRun;
                end
                default: state <= StRun;
            endcase
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        pc_redirect  = 1'b0;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        ex_mem_flush = 1'b0;
        if (!rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (mem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else begin
            unique case (state)
                StRun: begin
                    if (mc_start) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                    end else if (load_stall) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (branch_stall) begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                    end
                end
                StBrWait: begin
                    if (!br_resolve) begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                    end else if (br_taken) begin
                        pc_redirect = 1'b1;
                        if_id_flush = 1'b1;
                    end
                end
                StMcBusy: begin
                    if (cnt != 8'd0) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = rst && (state != StRun);

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [PERF_W-1:0] PerfOne = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;
    logic              any_flush;

    assign any_flush = if_id_flush | id_ex_flush | ex_mem_flush;

    // Reset holds both counters at zero, so reset cycles are never counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + PerfOne;
            if (any_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + PerfOne;
        end
    end

    assign perf_stall_cnt = stall_cnt;
    assign perf_flush_cnt = flush_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed vector table, reset sequences, and a
// randomized run compared against a behavioural model.
module tb_pipe_ctrl;

    localparam int unsigned MCL  = 4;
    localparam int unsigned PW   = 4;
    localparam int          MAXP = (1 << PW) - 1;

    // Input vector bit positions: {ls, bs, mc, brr, brt, mw}
    localparam logic [5:0] LS  = 6'b100000;
    localparam logic [5:0] BS  = 6'b010000;
    localparam logic [5:0] MC  = 6'b001000;
    localparam logic [5:0] BRR = 6'b000100;
    localparam logic [5:0] BRT = 6'b000010;
    localparam logic [5:0] MW  = 6'b000001;
    localparam logic [5:0] NON = 6'b000000;

    // Output vector: {pc_en, pc_redirect, if_id_en, if_id_flush,
    //                 id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush}
    localparam logic [7:0] O_DEF = 8'hAA;
    localparam logic [7:0] O_MC  = 8'h03;
    localparam logic [7:0] O_LD  = 8'h0E;
    localparam logic [7:0] O_BR  = 8'h3A;
    localparam logic [7:0] O_TK  = 8'hFA;
    localparam logic [7:0] O_MW  = 8'h00;
    localparam logic [7:0] O_RST = 8'h15;

    logic clk = 1'b0;
    logic rst;
    logic load_stall, branch_stall, mc_start, br_resolve, br_taken, mem_wait;
    logic pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic ex_mem_en, ex_mem_flush, busy;
    logic [PW-1:0] perf_stall_cnt, perf_flush_cnt;
    logic [7:0] o_act;

    assign o_act = {pc_en, pc_redirect, if_id_en, if_id_flush,
                    id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush};

    always #5 clk = ~clk;

    pipe_ctrl #(.MC_LAT(MCL), .PERF_W(PW)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_stall     (load_stall),
        .branch_stall   (branch_stall),
        .mc_start       (mc_start),
        .br_resolve     (br_resolve),
        .br_taken       (br_taken),
        .mem_wait       (mem_wait),
        .pc_en          (pc_en),
        .pc_redirect    (pc_redirect),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_ex_en       (id_ex_en),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_en      (ex_mem_en),
        .ex_mem_flush   (ex_mem_flush),
        .busy           (busy),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    int tests  = 0;
    int errors = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Behavioural model: a pending-branch flag and the number of busy cycles
    // left in a multi-cycle op (the last of which no longer stalls).
    bit m_brw;
    int m_mc_left;
    int m_stall;
    int m_flush;

    task automatic model_reset();
        m_brw     = 1'b0;
        m_mc_left = 0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    task automatic model_eval(input logic [5:0] v, output logic [7:0] o, output logic b);
        bit ls, bs, mc, brr, brt, mw;
        {ls, bs, mc, brr, brt, mw} = v;
        b = m_brw || (m_mc_left > 0);
        if (mw)                 o = O_MW;
        else if (m_mc_left > 1) o = O_MC;
        else if (m_mc_left == 1) o = O_DEF;
        else if (m_brw)         o = !brr ? O_BR : (brt ? O_TK : O_DEF);
        else if (mc)            o = O_MC;
        else if (ls)            o = O_LD;
        else if (bs)            o = O_BR;
        else                    o = O_DEF;
    endtask

    task automatic model_commit(input logic [5:0] v, input logic [7:0] o);
        bit ls, bs, mc, brr, brt, mw;
        {ls, bs, mc, brr, brt, mw} = v;
        if (!mw) begin
            if (m_mc_left > 0)  m_mc_left--;
            else if (m_brw)     m_brw = !brr;
            else if (mc)        m_mc_left = MCL - 1;
            else if (!ls && bs) m_brw = 1'b1;
        end
`ifdef PIPE_CTRL_PERF_EN
        if (!o[7]) m_stall = (m_stall < MAXP) ? m_stall + 1 : MAXP;
        if (o[4] || o[2] || o[0]) m_flush = (m_flush < MAXP) ? m_flush + 1 : MAXP;
`else
        if (o[7] === 1'bx) m_stall = 0;
`endif
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic run_cycle(input int idx, input logic [5:0] v, input bit use_tbl,
                             input logic [7:0] t_o, input logic t_b);
        logic [7:0] mo;
        logic       mb;
        {load_stall, branch_stall, mc_start, br_resolve, br_taken, mem_wait} = v;
        #2;
        model_eval(v, mo, mb);
        if (use_tbl) begin
            check("tbl_out", idx, 32'(o_act), 32'(t_o));
            check("tbl_busy", idx, 32'(busy), 32'(t_b));
        end else begin
            check("mdl_out", idx, 32'(o_act), 32'(mo));
            check("mdl_busy", idx, 32'(busy), 32'(mb));
        end
        check("perf_stall", idx, 32'(perf_stall_cnt), 32'(m_stall));
        check("perf_flush", idx, 32'(perf_flush_cnt), 32'(m_flush));
        model_commit(v, mo);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle, checked immediately, released at posedge+1.
    task automatic do_reset(input int idx);
        rst = 1'b0;
        #1;
        check("rst_out", idx, 32'(o_act), 32'(O_RST));
        check("rst_busy", idx, 32'(busy), 32'd0);
        check("rst_perf", idx, 32'({perf_stall_cnt, perf_flush_cnt}), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct packed {
        logic [5:0] in;
        logic [7:0] o;
        logic       b;
    } vec_t;

    vec_t tbl [33];

    initial begin
        tbl[0]  = '{NON,            O_DEF, 1'b0};
        tbl[1]  = '{MC,             O_MC,  1'b0};  // mc_start held 4 cycles
        tbl[2]  = '{MC,             O_MC,  1'b1};
        tbl[3]  = '{MC,             O_MC,  1'b1};
        tbl[4]  = '{MC,             O_DEF, 1'b1};
        tbl[5]  = '{NON,            O_DEF, 1'b0};
        tbl[6]  = '{BS,             O_BR,  1'b0};  // taken branch, 3 PC stalls
        tbl[7]  = '{NON,            O_BR,  1'b1};
        tbl[8]  = '{NON,            O_BR,  1'b1};
        tbl[9]  = '{BRR | BRT,      O_TK,  1'b1};
        tbl[10] = '{NON,            O_DEF, 1'b0};
        tbl[11] = '{BS,             O_BR,  1'b0};  // not-taken branch
        tbl[12] = '{BRR,            O_DEF, 1'b1};
        tbl[13] = '{NON,            O_DEF, 1'b0};
        tbl[14] = '{LS | BS,        O_LD,  1'b0};  // load wins over branch
        tbl[15] = '{NON,            O_DEF, 1'b0};
        tbl[16] = '{MC | LS | BS,   O_MC,  1'b0};  // mc wins over both
        tbl[17] = '{NON,            O_MC,  1'b1};  // cnt 2 -> 1
        tbl[18] = '{MW,             O_MW,  1'b1};  // 5 frozen cycles at cnt 1
        tbl[19] = '{MW | MC,        O_MW,  1'b1};
        tbl[20] = '{MW | BRR | BRT, O_MW,  1'b1};
        tbl[21] = '{MW | LS,        O_MW,  1'b1};
        tbl[22] = '{MW | BS,        O_MW,  1'b1};
        tbl[23] = '{NON,            O_MC,  1'b1};
        tbl[24] = '{NON,            O_DEF, 1'b1};
        tbl[25] = '{NON,            O_DEF, 1'b0};
        tbl[26] = '{BRR | BRT,      O_DEF, 1'b0};  // resolve ignored in RUN
        tbl[27] = '{MW | BS,        O_MW,  1'b0};
        tbl[28] = '{NON,            O_DEF, 1'b0};
        tbl[29] = '{BS,             O_BR,  1'b0};
        tbl[30] = '{MW | BRR | BRT, O_MW,  1'b1};  // frozen in BR_WAIT
        tbl[31] = '{BRR | BRT,      O_TK,  1'b1};
        tbl[32] = '{NON,            O_DEF, 1'b0};

        rst = 1'b0;
        {load_stall, branch_stall, mc_start, br_resolve, br_taken, mem_wait} = NON;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("init_out", 0, 32'(o_act), 32'(O_RST));
        check("init_busy", 0, 32'(busy), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 33; i++) run_cycle(i, tbl[i].in, 1'b1, tbl[i].o, tbl[i].b);

        // Reset in the middle of BR_WAIT; resolve afterwards must be ignored.
        run_cycle(100, BS, 1'b1, O_BR, 1'b0);
        run_cycle(101, NON, 1'b1, O_BR, 1'b1);
        do_reset(102);
        run_cycle(103, BRR | BRT, 1'b1, O_DEF, 1'b0);
        run_cycle(104, NON, 1'b1, O_DEF, 1'b0);

        // Reset in the middle of MC_BUSY.
        run_cycle(110, MC, 1'b1, O_MC, 1'b0);
        run_cycle(111, NON, 1'b1, O_MC, 1'b1);
        do_reset(112);
        run_cycle(113, NON, 1'b1, O_DEF, 1'b0);

        // Counter saturation: 20 stall cycles from reset.
        do_reset(120);
        for (int i = 0; i < 20; i++) run_cycle(121 + i, MW, 1'b1, O_MW, 1'b0);
        #2;
`ifdef PIPE_CTRL_PERF_EN
        check("perf_sat", 141, 32'(perf_stall_cnt), 32'd15);
`else
        check("perf_tied", 141, 32'(perf_stall_cnt), 32'd0);
`endif
        check("perf_flush_sat", 141, 32'(perf_flush_cnt), 32'd0);
        @(posedge clk);
        #1;

        // Randomized run against the model.
        do_reset(200);
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] v;
            if ($urandom_range(99) == 0) do_reset(1000 + i);
            v = NON;
            if ($urandom_range(99) < 20) v |= LS;
            if ($urandom_range(99) < 20) v |= BS;
            if ($urandom_range(99) < 10) v |= MC;
            if ($urandom_range(99) < 30) v |= BRR;
            if ($urandom_range(99) < 50) v |= BRT;
            if ($urandom_range(99) < 15) v |= MW;
            run_cycle(1000 + i, v, 1'b0, 8'h00, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
